// File: rtl/axicb_slv_switch.sv
// axicb_slv_switch
// Slave-side switch of the AXI crossbar. One master port fans out to SLV_NB
// slave ports. AW/AR are address decoded, W beats follow the AW order through
// a small routing FIFO, and B/R responses are merged back round-robin with the
// R grant held for a whole burst.
module axicb_slv_switch #(
    parameter int AXI_ADDR_W = 16,
    parameter int SLV_NB     = 4,
    parameter logic [AXI_ADDR_W-1:0] SLV0_START_ADDR = 'h0000,
    parameter logic [AXI_ADDR_W-1:0] SLV0_END_ADDR   = 'h0FFF,
    parameter logic [AXI_ADDR_W-1:0] SLV1_START_ADDR = 'h1000,
    parameter logic [AXI_ADDR_W-1:0] SLV1_END_ADDR   = 'h1FFF,
    parameter logic [AXI_ADDR_W-1:0] SLV2_START_ADDR = 'h2000,
    parameter logic [AXI_ADDR_W-1:0] SLV2_END_ADDR   = 'h2FFF,
    parameter logic [AXI_ADDR_W-1:0] SLV3_START_ADDR = 'h3000,
    parameter logic [AXI_ADDR_W-1:0] SLV3_END_ADDR   = 'h3FFF,
    parameter int DEFAULT_SLV = 0,
    parameter int WFIFO_DEPTH = 16,
    parameter int AWCH_W      = 8,
    parameter int WCH_W       = 8,
    parameter int BCH_W       = 8,
    parameter int ARCH_W      = 8,
    parameter int RCH_W       = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    srst,
    // master side
    input  logic                    i_awvalid,
    output logic                    i_awready,
    input  logic [AWCH_W-1:0]       i_awch,
    input  logic                    i_wvalid,
    output logic                    i_wready,
    input  logic                    i_wlast,
    input  logic [WCH_W-1:0]        i_wch,
    output logic                    i_bvalid,
    input  logic                    i_bready,
    output logic [BCH_W-1:0]        i_bch,
    input  logic                    i_arvalid,
    output logic                    i_arready,
    input  logic [ARCH_W-1:0]       i_arch,
    output logic                    i_rvalid,
    input  logic                    i_rready,
    output logic                    i_rlast,
    output logic [RCH_W-1:0]        i_rch,
    // slave side
    output logic [SLV_NB-1:0]       o_awvalid,
    input  logic [SLV_NB-1:0]       o_awready,
    output logic [AWCH_W-1:0]       o_awch,
    output logic [SLV_NB-1:0]       o_wvalid,
    input  logic [SLV_NB-1:0]       o_wready,
    output logic                    o_wlast,
    output logic [WCH_W-1:0]        o_wch,
    input  logic [SLV_NB-1:0]       o_bvalid,
    output logic [SLV_NB-1:0]       o_bready,
    input  logic [SLV_NB*BCH_W-1:0] o_bch,
    output logic [SLV_NB-1:0]       o_arvalid,
    input  logic [SLV_NB-1:0]       o_arready,
    output logic [ARCH_W-1:0]       o_arch,
    input  logic [SLV_NB-1:0]       o_rvalid,
    output logic [SLV_NB-1:0]       o_rready,
    input  logic [SLV_NB-1:0]       o_rlast,
    input  logic [SLV_NB*RCH_W-1:0] o_rch
);

    localparam int IDX_W = (SLV_NB > 1) ? $clog2(SLV_NB) : 1;
    localparam int PTR_W = $clog2(WFIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLV_NB - 1);

    function automatic logic inWindow(input logic [AXI_ADDR_W-1:0] addr,
                                      input logic [AXI_ADDR_W-1:0] lo,
                                      input logic [AXI_ADDR_W-1:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

    // Lowest matching window wins; no match falls back to DEFAULT_SLV.
    function automatic logic [SLV_NB-1:0] decode(input logic [AXI_ADDR_W-1:0] addr);
        logic [3:0] hit;
        logic [3:0] sel;
        logic       found;
        hit[0] = inWindow(addr, SLV0_START_ADDR, SLV0_END_ADDR);
        hit[1] = inWindow(addr, SLV1_START_ADDR, SLV1_END_ADDR);
        hit[2] = inWindow(addr, SLV2_START_ADDR, SLV2_END_ADDR);
        hit[3] = inWindow(addr, SLV3_START_ADDR, SLV3_END_ADDR);
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < SLV_NB; i++) begin
            if (!found && hit[i]) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
        if (!found) sel = 4'b0001 << DEFAULT_SLV;
        return sel[SLV_NB-1:0];
    endfunction

    // Round-robin: search starts at the slot after the last winner.
    function automatic logic [SLV_NB-1:0] rrPick(input logic [SLV_NB-1:0] req,
                                                 input logic [IDX_W-1:0]  last);
        logic [SLV_NB-1:0] gnt;
        logic              found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < SLV_NB; i++) begin
            if (!found && req[i] && (i > int'(last))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < SLV_NB; i++) begin
            if (!found && req[i] && (i <= int'(last))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic logic [IDX_W-1:0] toIdx(input logic [SLV_NB-1:0] oneHot);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < SLV_NB; i++) begin
            if (oneHot[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    logic                   outEn_q;
    logic                   outEn;
    logic [AXI_ADDR_W-1:0]  awAddr;
    logic [AXI_ADDR_W-1:0]  arAddr;
    logic [SLV_NB-1:0]      awSel;
    logic [SLV_NB-1:0]      arSel;
    logic [SLV_NB-1:0]      fifoMem_q [WFIFO_DEPTH];
    logic [PTR_W-1:0]       wrPtr_q;
    logic [PTR_W-1:0]       rdPtr_q;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic                   fifoEmpty;
    logic                   fifoFull;
    logic                   awPush;
    logic                   wPop;
    logic                   bypass;
    logic                   fifoWrite;
    logic                   fifoRead;
    logic [SLV_NB-1:0]      wHead;
    logic [IDX_W-1:0]       bPtr_q;
    logic                   bLock_q;
    logic [SLV_NB-1:0]      bGrant_q;
    logic [SLV_NB-1:0]      bGrant;
    logic [IDX_W-1:0]       rPtr_q;
    logic                   rLock_q;
    logic [SLV_NB-1:0]      rGrant_q;
    logic [SLV_NB-1:0]      rGrant;
    logic                   rDone;

    // Handshake outputs stay quiet during either reset and for one cycle after.
    assign outEn = outEn_q & ~srst;

    // The address sits in the low bits of the channel; narrow channels are zero-extended.
    if (AWCH_W >= AXI_ADDR_W) begin : gAwWide
        assign awAddr = i_awch[AXI_ADDR_W-1:0];
    end else begin : gAwNarrow
        assign awAddr = {{(AXI_ADDR_W-AWCH_W){1'b0}}, i_awch};
    end
    if (ARCH_W >= AXI_ADDR_W) begin : gArWide
        assign arAddr = i_arch[AXI_ADDR_W-1:0];
    end else begin : gArNarrow
        assign arAddr = {{(AXI_ADDR_W-ARCH_W){1'b0}}, i_arch};
    end

    assign awSel = decode(awAddr);
    assign arSel = decode(arAddr);

    assign o_awch    = i_awch;
    assign o_awvalid = awSel & {SLV_NB{i_awvalid & ~fifoFull & outEn}};
    assign i_awready = outEn & ~fifoFull & (|(awSel & o_awready));
    assign awPush    = i_awvalid & i_awready;

    assign o_arch    = i_arch;
    assign o_arvalid = arSel & {SLV_NB{i_arvalid & outEn}};
    assign i_arready = outEn & (|(arSel & o_arready));

    assign fifoEmpty = (count_q == '0);
    assign fifoFull  = (count_q == CNT_W'(WFIFO_DEPTH));

    // An empty FIFO passes the freshly pushed route straight to the W path.
    assign wHead = fifoEmpty ? (awPush ? awSel : '0) : fifoMem_q[rdPtr_q];

    assign o_wch    = i_wch;
    assign o_wlast  = i_wlast;
    assign o_wvalid = wHead & {SLV_NB{i_wvalid & outEn}};
    assign i_wready = outEn & (|(wHead & o_wready));
    assign wPop     = i_wvalid & i_wready & i_wlast;

    // A route consumed in its own push cycle never enters the storage.
    assign bypass    = fifoEmpty & awPush & wPop;
    assign fifoWrite = awPush & ~bypass;
    assign fifoRead  = wPop & ~bypass;
    assign count_d   = count_q + CNT_W'(fifoWrite) - CNT_W'(fifoRead);

    // Route storage needs no reset: entries are only read once counted in.
    always_ff @(posedge aclk) begin
        if (fifoWrite) fifoMem_q[wrPtr_q] <= awSel;
    end

    // Output enable flag plus W routing FIFO pointers and occupancy.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            outEn_q <= 1'b0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (srst) begin
            outEn_q <= 1'b0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            outEn_q <= 1'b1;
            if (fifoWrite) wrPtr_q <= wrPtr_q + 1'b1;
            if (fifoRead)  rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign bGrant   = bLock_q ? bGrant_q : rrPick(o_bvalid, bPtr_q);
    assign i_bvalid = outEn & (|(bGrant & o_bvalid));
    assign o_bready = bGrant & {SLV_NB{i_bready & outEn}};

    // Forward the granted slave's B payload.
    always_comb begin
        i_bch = '0;
        for (int i = 0; i < SLV_NB; i++) begin
            if (bGrant[i]) i_bch = o_bch[i*BCH_W +: BCH_W];
        end
    end

    // B arbiter: hold a stalled grant, advance the pointer on each handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bPtr_q   <= LAST_IDX;
            bLock_q  <= 1'b0;
            bGrant_q <= '0;
        end else if (srst) begin
            bPtr_q   <= LAST_IDX;
            bLock_q  <= 1'b0;
            bGrant_q <= '0;
        end else if (i_bvalid && i_bready) begin
            bPtr_q  <= toIdx(bGrant);
            bLock_q <= 1'b0;
        end else if (i_bvalid) begin
            bLock_q  <= 1'b1;
            bGrant_q <= bGrant;
        end
    end

    assign rGrant   = rLock_q ? rGrant_q : rrPick(o_rvalid, rPtr_q);
    assign i_rvalid = outEn & (|(rGrant & o_rvalid));
    assign o_rready = rGrant & {SLV_NB{i_rready & outEn}};
    assign rDone    = i_rvalid & i_rready & i_rlast;

    // Forward the granted slave's R payload and last flag.
    always_comb begin
        i_rch   = '0;
        i_rlast = 1'b0;
        for (int i = 0; i < SLV_NB; i++) begin
            if (rGrant[i]) begin
                i_rch   = o_rch[i*RCH_W +: RCH_W];
                i_rlast = o_rlast[i];
            end
        end
    end

    // R arbiter: lock on the first presented beat until the last beat is taken.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rPtr_q   <= LAST_IDX;
            rLock_q  <= 1'b0;
            rGrant_q <= '0;
        end else if (srst) begin
            rPtr_q   <= LAST_IDX;
            rLock_q  <= 1'b0;
            rGrant_q <= '0;
        end else if (rDone) begin
            rPtr_q  <= toIdx(rGrant);
            rLock_q <= 1'b0;
        end else if (i_rvalid) begin
            rLock_q  <= 1'b1;
            rGrant_q <= rGrant;
        end
    end

endmodule

// File: tb/tb_axicb_slv_switch.sv
// tb_axicb_slv_switch
// Directed bench for the slave-side crossbar switch: decode, W routing FIFO,
// B/R round-robin with R burst lock, and both reset flavours.
module tb_axicb_slv_switch;

   localparam int NB = 4;
   localparam int AW = 16;

   logic           aclk = 1'b0;
   logic           aresetn;
   logic           srst;
   logic           i_awvalid;
   logic           i_awready;
   logic [AW-1:0]  i_awch;
   logic           i_wvalid;
   logic           i_wready;
   logic           i_wlast;
   logic [7:0]     i_wch;
   logic           i_bvalid;
   logic           i_bready;
   logic [7:0]     i_bch;
   logic           i_arvalid;
   logic           i_arready;
   logic [AW-1:0]  i_arch;
   logic           i_rvalid;
   logic           i_rready;
   logic           i_rlast;
   logic [7:0]     i_rch;
   logic [NB-1:0]  o_awvalid;
   logic [NB-1:0]  o_awready;
   logic [AW-1:0]  o_awch;
   logic [NB-1:0]  o_wvalid;
   logic [NB-1:0]  o_wready;
   logic           o_wlast;
   logic [7:0]     o_wch;
   logic [NB-1:0]  o_bvalid;
   logic [NB-1:0]  o_bready;
   logic [NB*8-1:0] o_bch;
   logic [NB-1:0]  o_arvalid;
   logic [NB-1:0]  o_arready;
   logic [AW-1:0]  o_arch;
   logic [NB-1:0]  o_rvalid;
   logic [NB-1:0]  o_rready;
   logic [NB-1:0]  o_rlast;
   logic [NB*8-1:0] o_rch;

   int checks = 0;
   int errors = 0;

   axicb_slv_switch #(
      .AXI_ADDR_W (AW),
      .SLV_NB     (NB),
      .AWCH_W     (AW),
      .ARCH_W     (AW),
      .WCH_W      (8),
      .BCH_W      (8),
      .RCH_W      (8)
   ) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .srst      (srst),
      .i_awvalid (i_awvalid),
      .i_awready (i_awready),
      .i_awch    (i_awch),
      .i_wvalid  (i_wvalid),
      .i_wready  (i_wready),
      .i_wlast   (i_wlast),
      .i_wch     (i_wch),
      .i_bvalid  (i_bvalid),
      .i_bready  (i_bready),
      .i_bch     (i_bch),
      .i_arvalid (i_arvalid),
      .i_arready (i_arready),
      .i_arch    (i_arch),
      .i_rvalid  (i_rvalid),
      .i_rready  (i_rready),
      .i_rlast   (i_rlast),
      .i_rch     (i_rch),
      .o_awvalid (o_awvalid),
      .o_awready (o_awready),
      .o_awch    (o_awch),
      .o_wvalid  (o_wvalid),
      .o_wready  (o_wready),
      .o_wlast   (o_wlast),
      .o_wch     (o_wch),
      .o_bvalid  (o_bvalid),
      .o_bready  (o_bready),
      .o_bch     (o_bch),
      .o_arvalid (o_arvalid),
      .o_arready (o_arready),
      .o_arch    (o_arch),
      .o_rvalid  (o_rvalid),
      .o_rready  (o_rready),
      .o_rlast   (o_rlast),
      .o_rch     (o_rch)
   );

   // Free-running 10 ns clock.
   always #5 aclk = ~aclk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus();
      i_awvalid = 1'b0;
      i_awch    = '0;
      i_wvalid  = 1'b0;
      i_wlast   = 1'b0;
      i_wch     = '0;
      i_bready  = 1'b0;
      i_arvalid = 1'b0;
      i_arch    = '0;
      i_rready  = 1'b0;
      o_awready = '0;
      o_wready  = '0;
      o_bvalid  = '0;
      o_bch     = '0;
      o_arready = '0;
      o_rvalid  = '0;
      o_rlast   = '0;
      o_rch     = '0;
   endtask

   task automatic stepCycle();
      @(posedge aclk);
      #1;
   endtask

   // Main directed sequence.
   initial begin
      logic [AW-1:0] t2Addr [3];
      logic [NB-1:0] t2Sel [3];
      logic [7:0]    rSeq [6];
      logic [NB-1:0] expSlv;
      int            k;
      int            rem0;
      int            rem2;

      applyStimulus();
      aresetn = 1'b0;
      srst    = 1'b0;

      // Reset: requests pending everywhere, nothing may leak out.
      i_awvalid = 1'b1; i_awch = 16'h1234; o_awready = '1;
      i_arvalid = 1'b1; o_arready = '1;
      i_wvalid  = 1'b1; o_wready = '1;
      o_bvalid  = '1; i_bready = 1'b1;
      o_rvalid  = '1; i_rready = 1'b1;
      repeat (2) @(posedge aclk);
      #1;
      checkOutput("rst_awvalid", 32'(o_awvalid), 32'h0);
      checkOutput("rst_awready", 32'(i_awready), 32'h0);
      checkOutput("rst_wready",  32'(i_wready),  32'h0);
      checkOutput("rst_arvalid", 32'(o_arvalid), 32'h0);
      checkOutput("rst_bvalid",  32'(i_bvalid),  32'h0);
      checkOutput("rst_rready",  32'(o_rready),  32'h0);
      aresetn = 1'b1;
      #1;
      checkOutput("rel_awvalid", 32'(o_awvalid), 32'h0);
      checkOutput("rel_rvalid",  32'(i_rvalid),  32'h0);
      stepCycle();
      applyStimulus();

      // Single write to 'h1234 -> slave 1, 4-beat W, B from slave 1.
      i_awvalid = 1'b1; i_awch = 16'h1234; o_awready = 4'b0010;
      #1;
      checkOutput("t1_awvalid", 32'(o_awvalid), 32'h2);
      checkOutput("t1_awready", 32'(i_awready), 32'h1);
      stepCycle();
      i_awvalid = 1'b0; o_awready = '0;
      i_wvalid = 1'b1; o_wready = '1;
      for (int b = 0; b < 4; b++) begin
         i_wlast = (b == 3);
         i_wch   = 8'(8'h10 + b);
         #1;
         checkOutput("t1_wvalid", 32'(o_wvalid), 32'h2);
         checkOutput("t1_wready", 32'(i_wready), 32'h1);
         stepCycle();
      end
      i_wlast = 1'b0;
      #1;
      checkOutput("t1_empty_wready", 32'(i_wready), 32'h0);
      checkOutput("t1_empty_wvalid", 32'(o_wvalid), 32'h0);
      i_wvalid = 1'b0;
      o_bvalid = 4'b0010; o_bch = 32'h0000_B100; i_bready = 1'b1;
      #1;
      checkOutput("t1_bvalid", 32'(i_bvalid), 32'h1);
      checkOutput("t1_bch",    32'(i_bch),    32'hB1);
      checkOutput("t1_bready", 32'(o_bready), 32'h2);
      stepCycle();
      applyStimulus();

      // Three AWs queued with W held off, then drained in order.
      t2Addr = '{16'h2000, 16'h0100, 16'h3ABC};
      t2Sel  = '{4'b0100, 4'b0001, 4'b1000};
      o_awready = '1;
      for (int n = 0; n < 3; n++) begin
         i_awvalid = 1'b1; i_awch = t2Addr[n];
         #1;
         checkOutput("t2_awvalid", 32'(o_awvalid), 32'(t2Sel[n]));
         stepCycle();
      end
      i_awvalid = 1'b0;
      i_wvalid = 1'b1; o_wready = '1;
      for (int n = 0; n < 3; n++) begin
         for (int b = 0; b < 2; b++) begin
            i_wlast = (b == 1);
            #1;
            checkOutput("t2_wvalid", 32'(o_wvalid), 32'(t2Sel[n]));
            checkOutput("t2_wready", 32'(i_wready), 32'h1);
            stepCycle();
         end
      end
      i_wlast = 1'b0;
      #1;
      checkOutput("t2_empty_wready", 32'(i_wready), 32'h0);
      applyStimulus();

      // AW and its single W beat in the same cycle on an empty FIFO.
      o_awready = '1; o_wready = '1;
      i_awvalid = 1'b1; i_awch = 16'h1800; i_wvalid = 1'b1; i_wlast = 1'b1;
      #1;
      checkOutput("pt_wvalid", 32'(o_wvalid), 32'h2);
      checkOutput("pt_wready", 32'(i_wready), 32'h1);
      stepCycle();
      i_awvalid = 1'b0;
      #1;
      checkOutput("pt_empty_wready", 32'(i_wready), 32'h0);
      applyStimulus();

      // Fill the FIFO with 16 routes, 17th AW blocked until a burst completes.
      o_awready = '1; i_awvalid = 1'b1; i_awch = 16'h1000;
      for (int n = 0; n < 16; n++) begin
         #1;
         checkOutput("t3_fill_awready", 32'(i_awready), 32'h1);
         stepCycle();
      end
      #1;
      checkOutput("t3_full_awready", 32'(i_awready), 32'h0);
      checkOutput("t3_full_awvalid", 32'(o_awvalid), 32'h0);
      i_wvalid = 1'b1; i_wlast = 1'b1; o_wready = '1;
      #1;
      checkOutput("t3_pop_wready",   32'(i_wready),  32'h1);
      checkOutput("t3_pop_awready",  32'(i_awready), 32'h0);
      stepCycle();
      i_wvalid = 1'b0; i_wlast = 1'b0;
      #1;
      checkOutput("t3_reopen_awready", 32'(i_awready), 32'h1);
      stepCycle();
      i_awvalid = 1'b0;
      i_wvalid = 1'b1; i_wlast = 1'b1;
      for (int n = 0; n < 16; n++) begin
         #1;
         checkOutput("t3_drain_wvalid", 32'(o_wvalid), 32'h2);
         stepCycle();
      end
      #1;
      checkOutput("t3_drained_wready", 32'(i_wready), 32'h0);
      applyStimulus();

      // AR decode: unmapped goes to slave 0, 'h2345 to slave 2.
      i_arvalid = 1'b1; i_arch = 16'hFFFF; o_arready = 4'b0001;
      #1;
      checkOutput("ar_unmapped_valid", 32'(o_arvalid), 32'h1);
      checkOutput("ar_unmapped_ready", 32'(i_arready), 32'h1);
      i_arch = 16'h2345;
      #1;
      checkOutput("ar_s2_valid", 32'(o_arvalid), 32'h4);
      checkOutput("ar_s2_ready", 32'(i_arready), 32'h0);
      stepCycle();
      applyStimulus();

      // B round-robin: last winner was slave 1, so slave 2 beats slave 0.
      o_bvalid = 4'b0101; o_bch = 32'hB3B2_B1B0; i_bready = 1'b0;
      #1;
      checkOutput("brr_stall_bch",   32'(i_bch),    32'hB2);
      checkOutput("brr_stall_bready", 32'(o_bready), 32'h0);
      stepCycle();
      i_bready = 1'b1;
      #1;
      checkOutput("brr_take_bch",    32'(i_bch),    32'hB2);
      checkOutput("brr_take_bready", 32'(o_bready), 32'h4);
      stepCycle();
      o_bvalid = 4'b0001;
      #1;
      checkOutput("brr_next_bch",    32'(i_bch),    32'hB0);
      checkOutput("brr_next_bready", 32'(o_bready), 32'h1);
      stepCycle();
      applyStimulus();

      // Slaves 0 and 2 each offer a 3-beat R burst, master ready toggling.
      rSeq = '{8'hA0, 8'hA1, 8'hA2, 8'hC0, 8'hC1, 8'hC2};
      k = 0; rem0 = 3; rem2 = 3;
      for (int cyc = 0; cyc < 24 && k < 6; cyc++) begin
         o_rvalid = {1'b0, rem2 > 0, 1'b0, rem0 > 0};
         o_rlast  = {1'b0, rem2 == 1, 1'b0, rem0 == 1};
         o_rch    = {8'h00, 8'(8'hC0 + 3 - rem2), 8'h00, 8'(8'hA0 + 3 - rem0)};
         i_rready = (cyc % 2 == 1);
         #1;
         expSlv = (k < 3) ? 4'b0001 : 4'b0100;
         checkOutput("r_valid", 32'(i_rvalid), 32'h1);
         checkOutput("r_data",  32'(i_rch),    32'(rSeq[k]));
         checkOutput("r_last",  32'(i_rlast),  32'((k == 2) || (k == 5)));
         checkOutput("r_ready", 32'(o_rready), i_rready ? 32'(expSlv) : 32'h0);
         if (o_rready[0] && o_rvalid[0]) rem0--;
         if (o_rready[2] && o_rvalid[2]) rem2--;
         if (i_rvalid && i_rready) k++;
         stepCycle();
      end
      checkOutput("r_done_beats", 32'(k), 32'd6);
      applyStimulus();

      // Lock: slave 2 mid-burst keeps the grant although slave 0 is next in turn.
      i_rready = 1'b1;
      o_rvalid = 4'b0100; o_rlast = 4'b0000; o_rch = 32'h00D0_0000;
      #1;
      checkOutput("rl_first_data",  32'(i_rch),    32'hD0);
      checkOutput("rl_first_ready", 32'(o_rready), 32'h4);
      stepCycle();
      o_rvalid = 4'b0101; o_rlast = 4'b0101; o_rch = 32'h00D1_00E0;
      #1;
      checkOutput("rl_locked_data",  32'(i_rch),    32'hD1);
      checkOutput("rl_locked_ready", 32'(o_rready), 32'h4);
      stepCycle();
      o_rvalid = 4'b0001;
      #1;
      checkOutput("rl_next_data",  32'(i_rch),    32'hE0);
      checkOutput("rl_next_ready", 32'(o_rready), 32'h1);
      stepCycle();
      applyStimulus();

      // Async reset in the middle of a W burst and an R burst.
      o_awready = '1; i_awvalid = 1'b1; i_awch = 16'h1000;
      #1;
      stepCycle();
      i_awvalid = 1'b0;
      i_wvalid = 1'b1; i_wlast = 1'b0; o_wready = '1;
      #1;
      checkOutput("rst6_wpre_wready", 32'(i_wready), 32'h1);
      stepCycle();
      o_rvalid = 4'b1000; o_rlast = 4'b0000; o_rch = 32'hF000_0000; i_rready = 1'b1;
      #1;
      checkOutput("rst6_rpre_rready", 32'(o_rready), 32'h8);
      stepCycle();
      aresetn = 1'b0; i_awvalid = 1'b1;
      #1;
      checkOutput("rst6_wready",  32'(i_wready),  32'h0);
      checkOutput("rst6_wvalid",  32'(o_wvalid),  32'h0);
      checkOutput("rst6_rvalid",  32'(i_rvalid),  32'h0);
      checkOutput("rst6_rready",  32'(o_rready),  32'h0);
      checkOutput("rst6_awvalid", 32'(o_awvalid), 32'h0);
      stepCycle();
      aresetn = 1'b1;
      stepCycle();
      i_awvalid = 1'b0;
      o_rvalid = 4'b1001; o_rch = 32'hF100_005A;
      #1;
      checkOutput("rst6_fifo_empty", 32'(i_wready), 32'h0);
      checkOutput("rst6_no_wvalid",  32'(o_wvalid), 32'h0);
      checkOutput("rst6_unlock_ready", 32'(o_rready), 32'h1);
      checkOutput("rst6_unlock_data",  32'(i_rch),    32'h5A);
      stepCycle();
      applyStimulus();

      // Synchronous reset gates outputs, including the cycle after release.
      srst = 1'b1; o_awready = '1; i_awvalid = 1'b1; i_awch = 16'h1000;
      #1;
      checkOutput("srst_awvalid", 32'(o_awvalid), 32'h0);
      stepCycle();
      srst = 1'b0;
      #1;
      checkOutput("srst_rel_awvalid", 32'(o_awvalid), 32'h0);
      stepCycle();
      #1;
      checkOutput("srst_live_awvalid", 32'(o_awvalid), 32'h2);
      i_awvalid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
